reg_obs_unit: RTL and testbench
===============================

# reg_obs_unit

Parametrised register-observation unit that sits between the CPU register-file read port and the single-bit debug observation pin. It replaces the fixed one-register, one-bit observation path with a snapshot-and-shift engine. On request it captures one register, or all registers in turn, and serialises each word MSB-first with a framing strobe. Captured words are immune to CPU writes that occur during shifting.

## Interface

Parameters:
- DATA_W, 16 — register width and bits shifted per word; must be ≥ 2.
- NUM_REGS, 8 — number of architectural registers; must be ≥ 2.
- ADDR_W, $clog2(NUM_REGS) — register index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- obs_start  in  1  request strobe; sampled only in IDLE.
- obs_all  in  1  sampled with obs_start; 1 = dump registers 0..NUM_REGS-1, 0 = single register.
- obs_sel  in  ADDR_W  register index for single mode; sampled with obs_start.
- rf_addr  out  ADDR_W  address to the register-file combinational read port.
- rf_data  in  DATA_W  read data for rf_addr, same cycle.
- obs_busy  out  1  high in every state except IDLE.
- obs_frame  out  1  high while a word's bits are on obs_data.
- obs_data  out  1  serial bit, MSB first; 0 when obs_frame is low.
- obs_done  out  1  one-cycle pulse after the last bit of the last word.
- obs_err  out  1  one-cycle pulse on a rejected request.

## Operation

- Registered state: the FSM state, idx (ADDR_W), all_mode, shift_reg (DATA_W), bit_cnt ($clog2(DATA_W) bits), and err_q.
- rf_addr = idx at all times.
- The FSM has four states: IDLE, LOAD, SHIFT and DONE.
- IDLE, with obs_start=1:
  - If obs_all=0 and obs_sel ≥ NUM_REGS: err_q ← 1 and the FSM stays in IDLE.
  - Otherwise: idx ← obs_all ? 0 : obs_sel, all_mode ← obs_all, and the FSM moves to LOAD.
- LOAD lasts one cycle: shift_reg ← rf_data, bit_cnt ← DATA_W-1, then SHIFT.
- SHIFT:
  - obs_frame=1 and obs_data=shift_reg[DATA_W-1].
  - Each edge: shift_reg ← shift_reg<<1 and bit_cnt ← bit_cnt-1.
  - When bit_cnt=0: if all_mode and idx ≠ NUM_REGS-1, idx ← idx+1 and go to LOAD; otherwise go to DONE.
- DONE lasts one cycle: obs_done=1, then IDLE.
- obs_err = err_q. err_q clears on the following edge.
- obs_start is ignored outside IDLE: it is neither queued nor flagged.
- obs_busy, obs_frame, obs_data and obs_done are decoded from the state and shift_reg only, with no path from inputs. obs_data is gated to 0 outside SHIFT.
- idx increments only while in range. The NUM_REGS-1 check terminates the dump, so idx never wraps.

## Timing

- Reset (rst_n=0, asynchronous) takes effect immediately:
  - State = IDLE; idx, shift_reg, bit_cnt, all_mode and err_q = 0.
  - obs_busy, obs_frame, obs_data, obs_done and obs_err = 0; rf_addr = 0.
  - Reset mid-transfer aborts the transfer with no obs_done.
- Let obs_start be accepted at edge T0:
  - LOAD occupies T0→T1.
  - obs_frame is high from T1 to T1+DATA_W; bit k (MSB = k=0) is valid in cycle T1+k.
  - DONE occupies T1+DATA_W → T1+DATA_W+1.
- Single transfer: obs_busy is high for DATA_W+2 cycles (18 at DATA_W=16).
- All mode: each word is one LOAD cycle plus DATA_W SHIFT cycles, so frames are separated by exactly one low cycle. obs_busy is high for NUM_REGS·(DATA_W+1)+1 cycles.
- rf_data is sampled only at the LOAD→SHIFT edge. Register writes during SHIFT do not alter the word in flight.
- A rejected request pulses obs_err in the cycle after T0; obs_busy stays 0.
- obs_start may be re-asserted in the DONE cycle. It is ignored there, and a new request is accepted only from IDLE, at the earliest on the edge after DONE.

## Test plan

- Reset: hold rst_n=0 for 3 cycles, then release → every output reads 0 and rf_addr=0. Assert rst_n=0 mid-SHIFT → obs_frame, obs_busy and obs_data drop to 0 without waiting for a clock edge.
- Single read: r3=0xA5C3, obs_sel=3, obs_all=0, start at T0 →
  - obs_frame high for cycles T1..T16 with serial bits 1010010111000011;
  - obs_done pulses in cycle T17;
  - obs_busy high for 18 cycles.
- Full dump: register i=0x1000+i, obs_all=1 →
  - 8 frames carrying 0x1000..0x1007 in order, each separated by one low cycle;
  - obs_busy high for 137 cycles;
  - exactly one obs_done pulse.
- Invalid index: NUM_REGS=6, obs_sel=6, obs_all=0 → obs_err pulses for one cycle, obs_busy stays 0, no frame. A following start with obs_sel=5 succeeds.
- Snapshot isolation and busy ignore: r2=0x00FF. At SHIFT bit 4, change rf_data to 0xFFFF and pulse obs_start →
  - the serial stream is still 0000000011111111;
  - no second transfer, no obs_err.
- Restart after reset: abort a dump at word 3 via rst_n, then start single read r0=0x8001 → the bits are 1000000000000001 and obs_done pulses once.

Source files
------------

// File: rtl/reg_obs_unit_if.sv
// Request, register-file read and serial observation signals of reg_obs_unit.
// The master side requests snapshots and supplies read data; the slave side is the observation engine.
interface reg_obs_unit_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              obs_start;
  logic              obs_all;
  logic [ADDR_W-1:0] obs_sel;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              obs_busy;
  logic              obs_frame;
  logic              obs_data;
  logic              obs_done;
  logic              obs_err;

  modport master (
    output obs_start, obs_all, obs_sel, rf_data,
    input  rf_addr, obs_busy, obs_frame, obs_data, obs_done, obs_err
  );

  modport slave (
    input  obs_start, obs_all, obs_sel, rf_data,
    output rf_addr, obs_busy, obs_frame, obs_data, obs_done, obs_err
  );
endinterface

// File: rtl/reg_obs_unit.sv
// Snapshot-and-shift register observer: one LOAD cycle then DATA_W serial bits MSB-first per word.
// Requests are only sampled in IDLE; starts while busy are dropped, out-of-range indices pulse obs_err.
module reg_obs_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input logic           clk,
  input logic           rst_n,
  reg_obs_unit_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [ADDR_W:0]   NUM_REGS_V = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS-1);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W-1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              all_mode;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              err_q;
  logic              sel_oob;

  assign sel_oob = ({1'b0, bus.obs_sel} >= NUM_REGS_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      all_mode  <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.obs_start) begin
            if (!bus.obs_all && sel_oob) begin
              err_q <= 1'b1;
            end else begin
              idx      <= bus.obs_all ? '0 : bus.obs_sel;
              all_mode <= bus.obs_all;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          // The only rf_data sample point: later writes cannot reach the word in flight.
          shift_reg <= bus.rf_data;
          bit_cnt   <= LAST_BIT;
          state     <= SHIFT;
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            if (all_mode && (idx != LAST_IDX)) begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs depend only on state and shift_reg, so reset clears them without a clock.
  assign bus.rf_addr   = idx;
  assign bus.obs_busy  = (state != IDLE);
  assign bus.obs_frame = (state == SHIFT);
  assign bus.obs_data  = (state == SHIFT) & shift_reg[DATA_W-1];
  assign bus.obs_done  = (state == DONE);
  assign bus.obs_err   = err_q;
endmodule

// File: tb/tb_reg_obs_unit.sv
// Directed bench for reg_obs_unit: an 8-register and a 6-register instance fed by a register-file model.
module tb_reg_obs_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_obs_unit_if #(.DATA_W(16), .NUM_REGS(8)) bus8 ();
  reg_obs_unit_if #(.DATA_W(16), .NUM_REGS(6)) bus6 ();

  reg_obs_unit #(.DATA_W(16), .NUM_REGS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  reg_obs_unit #(.DATA_W(16), .NUM_REGS(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  logic [15:0] regs8 [8];
  assign bus8.rf_data = regs8[bus8.rf_addr];
  assign bus6.rf_data = {13'h0A00, bus6.rf_addr};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle monitor on the 8-register instance
  int          mon_cyc, mon_busy_cnt, mon_done_cnt, mon_err_cnt, mon_first_frame, mon_done_cyc;
  int          mon_bitpos, mon_low_run, mon_bad_gaps, mon_gaps, mon_bad_data;
  logic        mon_seen_busy, mon_seen_frame, mon_prev_frame;
  logic [15:0] mon_word;
  logic [15:0] mon_words [$];

  task automatic mon_reset();
    mon_cyc = 0; mon_busy_cnt = 0; mon_done_cnt = 0; mon_err_cnt = 0;
    mon_first_frame = -1; mon_done_cyc = -1; mon_bitpos = 0; mon_low_run = 0;
    mon_bad_gaps = 0; mon_gaps = 0; mon_bad_data = 0;
    mon_seen_busy = 1'b0; mon_seen_frame = 1'b0; mon_prev_frame = 1'b0;
    mon_word = '0;
    mon_words.delete();
  endtask

  task automatic mon_sample();
    if (bus8.obs_busy) begin mon_busy_cnt++; mon_seen_busy = 1'b1; end
    if (bus8.obs_done) begin mon_done_cnt++; mon_done_cyc = mon_cyc; end
    if (bus8.obs_err) mon_err_cnt++;
    if (bus8.obs_frame) begin
      if (!mon_prev_frame) begin
        if (mon_seen_frame) begin
          mon_gaps++;
          if (mon_low_run != 1) mon_bad_gaps++;
        end else begin
          mon_first_frame = mon_cyc;
        end
        mon_seen_frame = 1'b1;
      end
      mon_word = {mon_word[14:0], bus8.obs_data};
      mon_bitpos++;
      if (mon_bitpos == 16) begin
        mon_words.push_back(mon_word);
        mon_bitpos = 0;
      end
      mon_low_run = 0;
    end else begin
      mon_low_run++;
      if (bus8.obs_data !== 1'b0) mon_bad_data++;
    end
    mon_prev_frame = bus8.obs_frame;
    mon_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_sample();
  endtask

  task automatic start8(input logic all, input logic [2:0] sel);
    mon_reset();
    bus8.obs_all   = all;
    bus8.obs_sel   = sel;
    bus8.obs_start = 1'b1;
    tick();
    bus8.obs_start = 1'b0;
  endtask

  task automatic run_to_idle(input int limit);
    for (int n = 0; n < limit && bus8.obs_busy; n++) tick();
    chk("xfer_returns_idle", {31'b0, bus8.obs_busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] w6;
    int          f6;

    bus8.obs_start = 1'b0; bus8.obs_all = 1'b0; bus8.obs_sel = '0;
    bus6.obs_start = 1'b0; bus6.obs_all = 1'b0; bus6.obs_sel = '0;
    for (int i = 0; i < 8; i++) regs8[i] = 16'h1000 + 16'(i);
    mon_reset();

    // Reset held for 3 cycles, then released
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_busy",    {31'b0, bus8.obs_busy},  32'd0);
    chk("rst_frame",   {31'b0, bus8.obs_frame}, 32'd0);
    chk("rst_data",    {31'b0, bus8.obs_data},  32'd0);
    chk("rst_done",    {31'b0, bus8.obs_done},  32'd0);
    chk("rst_err",     {31'b0, bus8.obs_err},   32'd0);
    chk("rst_rf_addr", {29'b0, bus8.rf_addr},   32'd0);
    chk("rst_busy6",   {31'b0, bus6.obs_busy},  32'd0);

    // Single read of r3 = 0xA5C3
    regs8[3] = 16'hA5C3;
    start8(1'b0, 3'd3);
    chk("single_rf_addr",    {29'b0, bus8.rf_addr},  32'd3);
    chk("single_load_busy",  {31'b0, bus8.obs_busy}, 32'd1);
    chk("single_load_frame", {31'b0, bus8.obs_frame}, 32'd0);
    run_to_idle(40);
    chk("single_words",      mon_words.size(), 32'd1);
    if (mon_words.size() > 0) chk("single_bits", {16'b0, mon_words[0]}, 32'h0000A5C3);
    chk("single_first_frame", mon_first_frame, 32'd1);
    chk("single_done_cyc",    mon_done_cyc,    32'd17);
    chk("single_busy_cycles", mon_busy_cnt,    32'd18);
    chk("single_done_cnt",    mon_done_cnt,    32'd1);
    chk("single_data_gated",  mon_bad_data,    32'd0);
    regs8[3] = 16'h1003;

    // Full dump of 0x1000..0x1007
    start8(1'b1, 3'd5);
    run_to_idle(300);
    chk("dump_words", mon_words.size(), 32'd8);
    for (int i = 0; i < 8 && i < mon_words.size(); i++)
      chk($sformatf("dump_word%0d", i), {16'b0, mon_words[i]}, 32'h1000 + i);
    chk("dump_gaps",        mon_gaps,     32'd7);
    chk("dump_bad_gaps",    mon_bad_gaps, 32'd0);
    chk("dump_busy_cycles", mon_busy_cnt, 32'd137);
    chk("dump_done_cnt",    mon_done_cnt, 32'd1);
    chk("dump_err_cnt",     mon_err_cnt,  32'd0);
    chk("dump_data_gated",  mon_bad_data, 32'd0);

    // Invalid index on the 6-register instance, then a valid one
    bus6.obs_sel = 3'd6; bus6.obs_start = 1'b1;
    tick();
    bus6.obs_start = 1'b0;
    chk("inv_err_pulse", {31'b0, bus6.obs_err},   32'd1);
    chk("inv_busy",      {31'b0, bus6.obs_busy},  32'd0);
    tick();
    chk("inv_err_clear", {31'b0, bus6.obs_err},   32'd0);
    chk("inv_busy2",     {31'b0, bus6.obs_busy},  32'd0);
    chk("inv_no_frame",  {31'b0, bus6.obs_frame}, 32'd0);
    bus6.obs_sel = 3'd5; bus6.obs_start = 1'b1;
    tick();
    bus6.obs_start = 1'b0;
    chk("inv_next_busy", {31'b0, bus6.obs_busy}, 32'd1);
    w6 = '0; f6 = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      w6 = {w6[14:0], bus6.obs_data};
      f6 += int'(bus6.obs_frame);
    end
    chk("inv_next_word",   {16'b0, w6}, 32'h00005005);
    chk("inv_next_frames", f6,          32'd16);
    tick();
    chk("inv_next_done",   {31'b0, bus6.obs_done}, 32'd1);
    chk("inv_next_err",    {31'b0, bus6.obs_err},  32'd0);

    // Snapshot isolation: rewrite r2 and re-request while bit 4 is on the pin
    regs8[2] = 16'h00FF;
    start8(1'b0, 3'd2);
    for (int n = 0; n < 40 && bus8.obs_busy; n++) begin
      tick();
      if (mon_cyc == 6) begin
        regs8[2] = 16'hFFFF;
        bus8.obs_start = 1'b1;
      end else begin
        bus8.obs_start = 1'b0;
      end
    end
    bus8.obs_start = 1'b0;
    chk("snap_returns_idle", {31'b0, bus8.obs_busy}, 32'd0);
    chk("snap_words", mon_words.size(), 32'd1);
    if (mon_words.size() > 0) chk("snap_bits", {16'b0, mon_words[0]}, 32'h000000FF);
    chk("snap_busy_cycles", mon_busy_cnt, 32'd18);
    chk("snap_done_cnt",    mon_done_cnt, 32'd1);
    chk("snap_err_cnt",     mon_err_cnt,  32'd0);
    repeat (3) tick();
    chk("snap_no_second", mon_busy_cnt, 32'd18);
    regs8[2] = 16'h1002;

    // Abort a dump during word 3 with an asynchronous reset
    start8(1'b1, 3'd0);
    for (int n = 0; n < 200; n++) begin
      tick();
      if (mon_words.size() == 3 && bus8.obs_frame && mon_bitpos >= 2) break;
    end
    chk("abort_at_word3", mon_words.size(), 32'd3);
    chk("abort_in_shift", {31'b0, bus8.obs_frame}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_frame_async", {31'b0, bus8.obs_frame}, 32'd0);
    chk("abort_busy_async",  {31'b0, bus8.obs_busy},  32'd0);
    chk("abort_data_async",  {31'b0, bus8.obs_data},  32'd0);
    chk("abort_rf_addr",     {29'b0, bus8.rf_addr},   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("abort_no_done", mon_done_cnt, 32'd0);

    // Restart with a single read of r0 = 0x8001
    regs8[0] = 16'h8001;
    start8(1'b0, 3'd0);
    run_to_idle(40);
    chk("restart_words", mon_words.size(), 32'd1);
    if (mon_words.size() > 0) chk("restart_bits", {16'b0, mon_words[0]}, 32'h00008001);
    chk("restart_done_cnt",    mon_done_cnt, 32'd1);
    chk("restart_busy_cycles", mon_busy_cnt, 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
